data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Loads hit with zero wait. Misses fill in one memory cycle. Misaligned word loads bypass the cache.
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_byte,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    output logic                     mem_adtp,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    output logic [15:0]              miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;
    localparam logic [ADDRESS_WIDTH-3:0] ONE_WORD = 1;

    typedef enum logic [1:0] {IDLE, FILL, BYPASS, WRITE} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SETS-1:0]         r_valid;
    logic [TAG_W-1:0]        r_tag  [SETS];
    logic [DATA_WIDTH-1:0]   r_data [SETS];
    logic [15:0]             r_miss_count;

    logic [1:0]              w_offset;
    logic [IDX_W-1:0]        w_index;
    logic [TAG_W-1:0]        w_tag;
    logic [ADDRESS_WIDTH-3:0] w_word_p4;
    logic [IDX_W-1:0]        w_index_p4;
    logic [TAG_W-1:0]        w_tag_p4;
    logic                    w_misaligned;
    logic                    w_match;
    logic                    w_match_p4;
    logic                    w_hit;
    logic [7:0]              w_byte;

    assign w_offset     = cpu_addr[1:0];
    assign w_index      = cpu_addr[2 +: IDX_W];
    assign w_tag        = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
    // The following word wraps modulo 2^32, so a store at the top of memory reaches line 0.
    assign w_word_p4    = cpu_addr[ADDRESS_WIDTH-1:2] + ONE_WORD;
    assign w_index_p4   = w_word_p4[IDX_W-1:0];
    assign w_tag_p4     = w_word_p4[ADDRESS_WIDTH-3 -: TAG_W];
    assign w_misaligned = !cpu_byte && (w_offset != 2'b00);
    assign w_match      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_match_p4   = r_valid[w_index_p4] && (r_tag[w_index_p4] == w_tag_p4);
    assign w_hit        = w_match && !w_misaligned;
    assign w_byte       = r_data[w_index][{w_offset, 3'b000} +: 8];
    assign miss_count   = r_miss_count;

    // NOTE: every output is given a default before the case so no path leaves a latch behind.
    always_comb begin
        w_next_state = r_state;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        mem_a        = cpu_addr;
        mem_adtp     = cpu_byte;
        mem_we       = 1'b0;
        mem_wd       = cpu_wdata;
        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        w_next_state = WRITE;
                    end else if (w_misaligned) begin
                        w_next_state = BYPASS;
                    end else if (w_hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = cpu_byte ? {{(DATA_WIDTH-8){1'b0}}, w_byte} : r_data[w_index];
                    end else begin
                        w_next_state = FILL;
                    end
                end
            end
            FILL: begin
                mem_a        = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                mem_adtp     = 1'b0;
                w_next_state = IDLE;
            end
            BYPASS: begin
                mem_adtp     = 1'b0;
                cpu_rdata    = mem_rd;
                cpu_ready    = 1'b1;
                w_next_state = IDLE;
            end
            WRITE: begin
                mem_we       = 1'b1;
                cpu_ready    = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_next_state == FILL && r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
            if (r_state == FILL) begin
                r_valid[w_index] <= 1'b1;
            end
            if (r_state == WRITE && w_misaligned) begin
                if (w_match) begin
                    r_valid[w_index] <= 1'b0;
                end
                if (w_match_p4) begin
                    r_valid[w_index_p4] <= 1'b0;
                end
            end
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (r_state == FILL) begin
            r_data[w_index] <= mem_rd;
            r_tag[w_index]  <= w_tag;
        end else if (r_state == WRITE && w_match) begin
            if (cpu_byte) begin
                r_data[w_index][{w_offset, 3'b000} +: 8] <= cpu_wdata[7:0];
            end else if (w_offset == 2'b00) begin
                r_data[w_index] <= cpu_wdata;
            end
        end
    end

endmodule
